// File: rtl/poly_idx_sched.sv
// poly_idx_sched: coefficient-index sequencer and two-client arbiter.
// One client at a time owns a 9-bit index walker that streams 0..LAST
// over a valid/ready handshake.
// Optional feature macro: POLY_IDX_SCHED_RR_EN selects round-robin
// arbitration; when it is undefined, client 0 has fixed priority.
module poly_idx_sched #(
   parameter logic [8:0] LAST = 9'd350
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt,
   output logic       busy,
   output logic [8:0] idx,
   output logic       idx_vld,
   input  logic       idx_rdy,
   output logic       last,
   output logic [1:0] done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0] state;
   logic [1:0] owner;
   logic [1:0] pick;
   logic [8:0] idx_nxt;
   logic       accept;
   logic       at_last;
   logic       abort;

   // 9-bit incrementer built on a Sklansky AND-prefix tree over the low
   // 8 bits: carry into bit i is the AND of bits 0..i-1.
   function automatic logic [8:0] inc_i9_o9(input logic [8:0] a);
      logic [7:0] p;
      logic [7:0] q;
      p = a[7:0];
      for (int lvl = 0; lvl < 3; lvl++) begin
         q = p;
         for (int i = 0; i < 8; i++) begin
            if (((i >> lvl) & 1) == 1)
               p[i] = q[i] & q[((i >> lvl) << lvl) - 1];
         end
      end
      return a ^ {p, 1'b1};
   endfunction

   assign idx_nxt = inc_i9_o9(idx);
   assign idx_vld = (state == ST_RUN);
   assign accept  = idx_vld & idx_rdy;
   assign at_last = (idx == LAST);
   assign abort   = idx_vld & ~(|(req & owner));
   assign last    = idx_vld & at_last;
   assign busy    = (state != ST_IDLE);
   assign gnt     = idx_vld ? owner : 2'b00;
   assign done    = (state == ST_DONE) ? owner : 2'b00;

`ifdef POLY_IDX_SCHED_RR_EN
   logic ptr;

   // Round-robin winner selection: the pointer breaks ties.
   always_comb begin
      pick = req;
      if (req == 2'b11)
         pick = ptr ? 2'b10 : 2'b01;
   end

   // Pointer moves to the losing client after every completed sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ptr <= 1'b0;
      else if (state == ST_DONE)
         ptr <= owner[0];
   end
`else
   // Fixed priority: client 0 always wins a tie.
   always_comb begin
      pick = req[0] ? 2'b01 : {req[1], 1'b0};
   end
`endif

   // Main sequencer: grant, walk the index, complete or abort.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         owner <= 2'b00;
         idx   <= 9'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  owner <= pick;
                  idx   <= 9'd0;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (accept && at_last) begin
                  state <= ST_DONE;
                  idx   <= 9'd0;
               end else if (abort) begin
                  state <= ST_IDLE;
                  owner <= 2'b00;
                  idx   <= 9'd0;
               end else if (accept) begin
                  idx <= idx_nxt;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               owner <= 2'b00;
               idx   <= 9'd0;
            end
            default: begin
               state <= ST_IDLE;
               owner <= 2'b00;
               idx   <= 9'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_poly_idx_sched.sv
// tb_poly_idx_sched: directed, table-driven bench for poly_idx_sched.
// Three instances (LAST = 350, 0, 511) share the clock, reset and ready;
// only the selected instance sees the request vector.
module tb_poly_idx_sched;

   logic       clk;
   logic       rst_n;
   logic [1:0] req;
   logic       idx_rdy;
   int         sel;

   logic [1:0] req_m, req_z, req_x;
   logic [1:0] gnt_m, gnt_z, gnt_x;
   logic       busy_m, busy_z, busy_x;
   logic [8:0] idx_m, idx_z, idx_x;
   logic       vld_m, vld_z, vld_x;
   logic       last_m, last_z, last_x;
   logic [1:0] done_m, done_z, done_x;

   logic [1:0] cur_gnt;
   logic       cur_busy;
   logic [8:0] cur_idx;
   logic       cur_vld;
   logic       cur_last;
   logic [1:0] cur_done;

   int n_cmp;
   int n_bad;

   typedef struct {
      logic [1:0] req;
      logic       rdy;
      logic [1:0] gnt;
      logic       busy;
      logic       vld;
      logic [8:0] idx;
      logic       last;
      logic [1:0] done;
   } vec_t;

   vec_t       tbl [12];
   logic [1:0] sim_exp [3];

   assign req_m = (sel == 0) ? req : 2'b00;
   assign req_z = (sel == 1) ? req : 2'b00;
   assign req_x = (sel == 2) ? req : 2'b00;

   poly_idx_sched #(.LAST(9'd350)) u_main (
      .clk(clk), .rst_n(rst_n), .req(req_m), .gnt(gnt_m), .busy(busy_m),
      .idx(idx_m), .idx_vld(vld_m), .idx_rdy(idx_rdy), .last(last_m), .done(done_m)
   );

   poly_idx_sched #(.LAST(9'd0)) u_zero (
      .clk(clk), .rst_n(rst_n), .req(req_z), .gnt(gnt_z), .busy(busy_z),
      .idx(idx_z), .idx_vld(vld_z), .idx_rdy(idx_rdy), .last(last_z), .done(done_z)
   );

   poly_idx_sched #(.LAST(9'd511)) u_max (
      .clk(clk), .rst_n(rst_n), .req(req_x), .gnt(gnt_x), .busy(busy_x),
      .idx(idx_x), .idx_vld(vld_x), .idx_rdy(idx_rdy), .last(last_x), .done(done_x)
   );

   // Route the selected instance's outputs to the checkers.
   always_comb begin
      cur_gnt  = gnt_m;
      cur_busy = busy_m;
      cur_idx  = idx_m;
      cur_vld  = vld_m;
      cur_last = last_m;
      cur_done = done_m;
      if (sel == 1) begin
         cur_gnt  = gnt_z;
         cur_busy = busy_z;
         cur_idx  = idx_z;
         cur_vld  = vld_z;
         cur_last = last_z;
         cur_done = done_z;
      end else if (sel == 2) begin
         cur_gnt  = gnt_x;
         cur_busy = busy_x;
         cur_idx  = idx_x;
         cur_vld  = vld_x;
         cur_last = last_x;
         cur_done = done_x;
      end
   end

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] r, input logic rdy);
      req     = r;
      idx_rdy = rdy;
   endtask

   task automatic checkOutput(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, " gnt"}, cur_gnt, 0);
      checkOutput({tag, " busy"}, cur_busy, 0);
      checkOutput({tag, " vld"}, cur_vld, 0);
      checkOutput({tag, " idx"}, cur_idx, 0);
      checkOutput({tag, " last"}, cur_last, 0);
      checkOutput({tag, " done"}, cur_done, 0);
   endtask

   task automatic startSweep(input logic [1:0] r, input logic [1:0] eg, input int lastv);
      applyStimulus(r, 1'b1);
      tick();
      checkOutput("grant gnt", cur_gnt, eg);
      checkOutput("grant busy", cur_busy, 1);
      checkOutput("grant vld", cur_vld, 1);
      checkOutput("grant idx", cur_idx, 0);
      checkOutput("grant last", cur_last, (lastv == 0) ? 1 : 0);
      checkOutput("grant done", cur_done, 0);
   endtask

   // Walk the rest of a sweep, checking every beat, then the done pulse.
   task automatic runRest(input int start, input int lastv, input logic [1:0] eg, input bit stall);
      int  exp_idx;
      bit  fin;
      logic rdy;
      exp_idx = start;
      fin     = 0;
      for (int c = 0; c < 1500 && !fin; c++) begin
         checkOutput("beat idx", cur_idx, exp_idx);
         checkOutput("beat vld", cur_vld, 1);
         checkOutput("beat last", cur_last, (exp_idx == lastv) ? 1 : 0);
         checkOutput("beat gnt", cur_gnt, eg);
         checkOutput("beat done", cur_done, 0);
         rdy = !(stall && (c % 4 == 1));
         idx_rdy = rdy;
         tick();
         if (rdy) begin
            if (exp_idx == lastv) fin = 1;
            else exp_idx++;
         end
      end
      if (!fin) checkOutput("sweep timeout", 0, 1);
      checkOutput("done pulse", cur_done, eg);
      checkOutput("done gnt", cur_gnt, 0);
      checkOutput("done vld", cur_vld, 0);
      checkOutput("done busy", cur_busy, 1);
      checkOutput("done last", cur_last, 0);
      tick();
      checkOutput("after done", cur_done, 0);
      checkOutput("after busy", cur_busy, 0);
      checkOutput("after gnt", cur_gnt, 0);
   endtask

   task automatic advanceTo(input int target);
      idx_rdy = 1'b1;
      for (int c = 0; c < 600 && cur_idx != 9'(target); c++) tick();
      checkOutput("advance idx", cur_idx, target);
   endtask

   // Test sequence.
   initial begin
      n_cmp = 0;
      n_bad = 0;
      sel   = 0;
      rst_n = 1'b0;
      applyStimulus(2'b00, 1'b0);

      tbl[0]  = '{2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 9'd0, 1'b0, 2'b00};
      tbl[1]  = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 9'd0, 1'b0, 2'b00};
      tbl[2]  = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 9'd0, 1'b0, 2'b00};
      tbl[3]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd1, 1'b0, 2'b00};
      tbl[4]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd2, 1'b0, 2'b00};
      tbl[5]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd3, 1'b0, 2'b00};
      tbl[6]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd4, 1'b0, 2'b00};
      tbl[7]  = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd5, 1'b0, 2'b00};
      tbl[8]  = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 9'd5, 1'b0, 2'b00};
      tbl[9]  = '{2'b01, 1'b0, 2'b01, 1'b1, 1'b1, 9'd5, 1'b0, 2'b00};
      tbl[10] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd6, 1'b0, 2'b00};
      tbl[11] = '{2'b01, 1'b1, 2'b01, 1'b1, 1'b1, 9'd7, 1'b0, 2'b00};

`ifdef POLY_IDX_SCHED_RR_EN
      sim_exp[0] = 2'b01;
      sim_exp[1] = 2'b10;
      sim_exp[2] = 2'b01;
`else
      sim_exp[0] = 2'b01;
      sim_exp[1] = 2'b01;
      sim_exp[2] = 2'b01;
`endif

      #3;
      checkIdle("reset");
      tick();
      tick();
      rst_n = 1'b1;

      $display("[TB] single sweep with backpressure, client 0");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i].req, tbl[i].rdy);
         tick();
         checkOutput($sformatf("row%0d gnt", i), cur_gnt, tbl[i].gnt);
         checkOutput($sformatf("row%0d busy", i), cur_busy, tbl[i].busy);
         checkOutput($sformatf("row%0d vld", i), cur_vld, tbl[i].vld);
         checkOutput($sformatf("row%0d idx", i), cur_idx, tbl[i].idx);
         checkOutput($sformatf("row%0d last", i), cur_last, tbl[i].last);
         checkOutput($sformatf("row%0d done", i), cur_done, tbl[i].done);
      end
      runRest(7, 350, 2'b01, 0);
      applyStimulus(2'b00, 1'b1);
      tick();
      checkIdle("idle1");

      $display("[TB] abort by client 1 at idx 100");
      startSweep(2'b10, 2'b10, 350);
      advanceTo(100);
      applyStimulus(2'b00, 1'b1);
      tick();
      checkIdle("abort");
      tick();
      checkIdle("abort2");
      startSweep(2'b10, 2'b10, 350);
      runRest(0, 350, 2'b10, 1);
      applyStimulus(2'b00, 1'b1);
      tick();

      $display("[TB] reset at idx 200");
      startSweep(2'b01, 2'b01, 350);
      advanceTo(200);
      rst_n = 1'b0;
      #1;
      checkIdle("async rst");
      applyStimulus(2'b00, 1'b1);
      tick();
      checkIdle("in rst");
      rst_n = 1'b1;
      startSweep(2'b01, 2'b01, 350);
      runRest(0, 350, 2'b01, 0);
      applyStimulus(2'b00, 1'b1);
      tick();

      $display("[TB] simultaneous requests after reset");
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int s = 0; s < 3; s++) begin
         startSweep(2'b11, sim_exp[s], 350);
         runRest(0, 350, sim_exp[s], 0);
      end
      applyStimulus(2'b00, 1'b1);
      tick();
      checkIdle("idle sim");

      $display("[TB] LAST = 0");
      sel = 1;
      #1;
      checkIdle("zero idle");
      startSweep(2'b01, 2'b01, 0);
      runRest(0, 0, 2'b01, 0);
      applyStimulus(2'b00, 1'b1);
      tick();

      $display("[TB] LAST = 511");
      sel = 2;
      #1;
      checkIdle("max idle");
      startSweep(2'b10, 2'b10, 511);
      runRest(0, 511, 2'b10, 0);
      applyStimulus(2'b00, 1'b1);
      tick();
      checkIdle("max end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
